// File: rtl/alu_seq16.sv
// alu_seq16 -- 16-bit operation sequencer in front of a combinational 8-bit ALU.
//
// Accepts one 16-bit request (valid/ready), runs it as byte-wide ALU passes
// (LO then HI, repeated once per shifted bit), chains carries and shift bits
// between passes, and presents a registered result (valid/ready).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (ready == FSM in IDLE)
//   req_op                     0 ADD, 1 XOR, 2 NOT, 3 CMP, 4 SHL, 5 SHR, 6-7 illegal
//   op_a, op_b, sh_amt         operands and shift count
//   rsp_valid/rsp_ready        response handshake
//   result, carry, gt, eq, err response word and flags
//   aluop, mode, dat_a, dat_b, sci, ci, odd   ALU drive
//   rslt, sco, co, alu_gt, alu_eq             ALU returns
//
// Build option: ALU_SEQ_SHIFT_EN enables SHL/SHR. Without it ops 4/5 are
// illegal, sh_amt is ignored and the shift counter/chaining logic is absent.
module alu_seq16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic [3:0]  sh_amt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] result,
  output logic        carry,
  output logic        gt,
  output logic        eq,
  output logic        err,
  output logic [2:0]  aluop,
  output logic [1:0]  mode,
  output logic [7:0]  dat_a,
  output logic [7:0]  dat_b,
  output logic        sci,
  output logic        ci,
  output logic        odd,
  input  logic [7:0]  rslt,
  input  logic        sco,
  input  logic        co,
  input  logic        alu_gt,
  input  logic        alu_eq
);

  localparam logic [2:0] OP_ADD = 3'd0, OP_XOR = 3'd1, OP_NOT = 3'd2,
                         OP_CMP = 3'd3, OP_SHL = 3'd4, OP_SHR = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] a;   // working word for shifts
    logic [15:0] b;
  } req_t;

  state_t     state_q, state_d;
  req_t       req_q;
  logic [7:0] p1_q;     // first-pass ALU result
  logic       co_q, gt_lo_q, eq_lo_q;
  logic       legal, zero_shift, hi_pass;

`ifdef ALU_SEQ_SHIFT_EN
  logic [3:0]  cnt_q;
  logic        sco_q;
  logic        shift_q;
  logic [15:0] shl_word, shr_word;

  assign legal      = (req_op <= OP_SHR);
  assign zero_shift = ((req_op == OP_SHL) || (req_op == OP_SHR)) && (sh_amt == 4'd0);
  assign shift_q    = (req_q.op == OP_SHL) || (req_q.op == OP_SHR);
  // SHL: lo-pass SCo feeds hi byte bit0.
  assign shl_word   = {rslt[7:1], sco_q, p1_q};
  // SHR: LO pass ran on the hi byte, so p1_q is the new hi byte; the bit
  // leaving the hi byte enters lo byte bit7.
  assign shr_word   = {p1_q, req_q.a[8], rslt[6:0]};
`else
  logic unused;
  assign unused     = ^{sh_amt, sco};
  assign legal      = (req_op <= OP_CMP);
  assign zero_shift = 1'b0;
`endif

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid) state_d = (!legal || zero_shift) ? S_DONE : S_LO;
      S_LO:   state_d = S_HI;
      S_HI: begin
        state_d = S_DONE;
`ifdef ALU_SEQ_SHIFT_EN
        if (shift_q && cnt_q != 4'd1) state_d = S_LO;
`endif
      end
      S_DONE: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU drive: idle pattern outside LO/HI
  always_comb begin
    aluop   = 3'b010;
    mode    = 2'b00;
    dat_a   = 8'h00;
    dat_b   = 8'h00;
    sci     = 1'b0;
    ci      = 1'b0;
    odd     = 1'b0;
    hi_pass = (state_q == S_HI);
`ifdef ALU_SEQ_SHIFT_EN
    if (req_q.op == OP_SHR) hi_pass = (state_q == S_LO);
`endif
    if (state_q == S_LO || state_q == S_HI) begin
      dat_a = hi_pass ? req_q.a[15:8] : req_q.a[7:0];
      case (req_q.op)
        OP_ADD, OP_CMP: begin
          aluop = 3'b000;
          dat_b = hi_pass ? req_q.b[15:8] : req_q.b[7:0];
          ci    = (state_q == S_HI) ? co_q : 1'b0;
        end
        OP_XOR: begin
          aluop = 3'b001;
          dat_b = hi_pass ? req_q.b[15:8] : req_q.b[7:0];
        end
        OP_NOT: begin aluop = 3'b101; mode = 2'b01; end
`ifdef ALU_SEQ_SHIFT_EN
        OP_SHL: begin aluop = 3'b101; mode = 2'b00; end
        OP_SHR: begin aluop = 3'b101; mode = 2'b10; end
`endif
        default: begin aluop = 3'b010; dat_a = 8'h00; end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q   <= '0;
      p1_q    <= 8'h00;
      co_q    <= 1'b0;
      gt_lo_q <= 1'b0;
      eq_lo_q <= 1'b0;
      result  <= 16'h0000;
      carry   <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      err     <= 1'b0;
`ifdef ALU_SEQ_SHIFT_EN
      cnt_q   <= 4'd0;
      sco_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          req_q  <= '{op: req_op, a: op_a, b: op_b};
          result <= zero_shift ? op_a : 16'h0000;
          carry  <= 1'b0;
          gt     <= 1'b0;
          eq     <= 1'b0;
          err    <= !legal;
`ifdef ALU_SEQ_SHIFT_EN
          cnt_q  <= sh_amt;
`endif
        end
        S_LO: begin
          p1_q    <= rslt;
          co_q    <= co;
          gt_lo_q <= alu_gt;
          eq_lo_q <= alu_eq;
`ifdef ALU_SEQ_SHIFT_EN
          sco_q   <= sco;
`endif
        end
        S_HI: begin
          case (req_q.op)
            OP_ADD: begin result <= {rslt, p1_q}; carry <= co; end
            OP_XOR, OP_NOT: result <= {rslt, p1_q};
            OP_CMP: begin
              gt <= alu_gt | (alu_eq & gt_lo_q);
              eq <= alu_eq & eq_lo_q;
            end
`ifdef ALU_SEQ_SHIFT_EN
            OP_SHL: begin
              req_q.a <= shl_word;
              cnt_q   <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin result <= shl_word; carry <= sco; end
            end
            OP_SHR: begin
              req_q.a <= shr_word;
              cnt_q   <= cnt_q - 4'd1;
              if (cnt_q == 4'd1) begin result <= shr_word; carry <= req_q.a[0]; end
            end
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq16.sv
// tb_alu_seq16 -- directed + randomized bench for alu_seq16 with a behavioural
// 8-bit ALU attached and a word-level reference model.
module tb_alu_seq16;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [2:0]  req_op = '0;
  logic [15:0] op_a = '0, op_b = '0;
  logic [3:0]  sh_amt = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [15:0] result;
  logic        carry, gt, eq, err;
  logic [2:0]  aluop;
  logic [1:0]  mode;
  logic [7:0]  dat_a, dat_b;
  logic        sci, ci, odd;
  logic [7:0]  rslt;
  logic        sco, co, alu_gt, alu_eq;

  int ncmp = 0, nerr = 0;

  alu_seq16 dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .op_a(op_a), .op_b(op_b), .sh_amt(sh_amt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .result(result),
    .carry(carry), .gt(gt), .eq(eq), .err(err), .aluop(aluop), .mode(mode),
    .dat_a(dat_a), .dat_b(dat_b), .sci(sci), .ci(ci), .odd(odd),
    .rslt(rslt), .sco(sco), .co(co), .alu_gt(alu_gt), .alu_eq(alu_eq));

  always #5 clk = ~clk;

  // 8-bit combinational ALU
  always_comb begin
    rslt = 8'h00; co = 1'b0; sco = 1'b0;
    alu_gt = (dat_a > dat_b);
    alu_eq = (dat_a == dat_b);
    case (aluop)
      3'b000: {co, rslt} = {1'b0, dat_a} + {1'b0, dat_b} + {8'h00, ci};
      3'b001: rslt = dat_a ^ dat_b;
      3'b101: case (mode)
        2'b00: begin rslt = {dat_a[6:0], 1'b0}; sco = dat_a[7]; end
        2'b10: begin rslt = {1'b0, dat_a[7:1]}; sco = dat_a[0]; end
        2'b01: rslt = ~dat_a;
        default: rslt = 8'h00;
      endcase
      default: rslt = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word-level reference: result, flags and accept-to-valid latency
  task automatic model(input logic [2:0] op, input logic [15:0] a, b, input logic [3:0] sh,
                       output logic [15:0] r, output logic c, g, e, er, output int lat);
    r = 16'h0; c = 1'b0; g = 1'b0; e = 1'b0; er = 1'b0; lat = 3;
    case (op)
      3'd0: {c, r} = {1'b0, a} + {1'b0, b};
      3'd1: r = a ^ b;
      3'd2: r = ~a;
      3'd3: begin g = (a > b); e = (a == b); end
`ifdef ALU_SEQ_SHIFT_EN
      3'd4: begin
        lat = 1 + 2 * int'(sh);
        if (sh == 0) r = a; else begin r = a << sh; c = a[16 - int'(sh)]; end
      end
      3'd5: begin
        lat = 1 + 2 * int'(sh);
        if (sh == 0) r = a; else begin r = a >> sh; c = a[int'(sh) - 1]; end
      end
`endif
      default: begin er = 1'b1; lat = 1; end
    endcase
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [15:0] a, b,
                     input logic [3:0] sh, input int bp);
    logic [15:0] er_r; logic ec, eg, ee, eerr; int elat, lat;
    model(op, a, b, sh, er_r, ec, eg, ee, eerr, elat);
    @(negedge clk);
    chk({tag, ".req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; op_a = a; op_b = b; sh_amt = sh;
    @(posedge clk); #1;
    req_valid = 1'b0; op_a = 16'($urandom); op_b = 16'($urandom); sh_amt = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 64) begin @(posedge clk); #1; lat++; end
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".result"}, result, er_r);
    chk({tag, ".carry"}, carry, ec);
    chk({tag, ".gt"}, gt, eg);
    chk({tag, ".eq"}, eq, ee);
    chk({tag, ".err"}, err, eerr);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({tag, ".bp_valid"}, rsp_valid, 1);
      chk({tag, ".bp_result"}, result, er_r);
      chk({tag, ".bp_ready"}, req_ready, 0);
      req_valid = 1'b1; req_op = 3'd1; op_a = 16'hDEAD; op_b = 16'hBEEF;
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, ".post_valid"}, rsp_valid, 0);
    chk({tag, ".post_result"}, result, er_r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    #12;
    chk("rst.req_ready", req_ready, 1);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.result", result, 0);
    chk("rst.flags", {carry, gt, eq, err}, 0);
    chk("rst.aluop", aluop, 3'b010);
    chk("rst.drive", {mode, dat_a, dat_b, sci, ci, odd}, 0);
    @(negedge clk); rst_n = 1'b1;

    run("add_ff_1",   3'd0, 16'h00FF, 16'h0001, 4'd0, 0);
    run("add_wrap",   3'd0, 16'hFFFF, 16'h0001, 4'd0, 0);
    run("cmp_gt",     3'd3, 16'h1234, 16'h1233, 4'd0, 0);
    run("cmp_eq",     3'd3, 16'hABCD, 16'hABCD, 4'd0, 0);
    run("cmp_lt",     3'd3, 16'h00FF, 16'h0100, 4'd0, 0);
    run("not",        3'd2, 16'h5A0F, 16'h1111, 4'd0, 0);
    run("shl_1",      3'd4, 16'h8181, 16'h0000, 4'd1, 0);
    run("shr_4",      3'd5, 16'h8181, 16'h0000, 4'd4, 0);
    run("shl_0",      3'd4, 16'hC3A5, 16'h0000, 4'd0, 0);
    run("shr_15",     3'd5, 16'h8001, 16'h0000, 4'd15, 0);
    run("illegal6",   3'd6, 16'h1234, 16'h5678, 4'd3, 0);
    run("illegal7",   3'd7, 16'h0000, 16'h0000, 4'd0, 0);
    run("backpress",  3'd0, 16'h1357, 16'h2468, 4'd0, 5);

    // reset during the HI pass of an ADD
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; op_a = 16'h1234; op_b = 16'h1111;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid.hi_aluop", aluop, 3'b000);
    rst_n = 1'b0; #1;
    chk("rst_mid.req_ready", req_ready, 1);
    chk("rst_mid.rsp_valid", rsp_valid, 0);
    chk("rst_mid.result", result, 0);
    chk("rst_mid.flags", {carry, gt, eq, err}, 0);
    chk("rst_mid.aluop", aluop, 3'b010);
    chk("rst_mid.drive", {mode, dat_a, dat_b, sci, ci, odd}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    chk("rst_mid.no_rsp", seen, 0);
    run("xor_after_rst", 3'd1, 16'h0F0F, 16'h00FF, 4'd0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op; logic [15:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      run($sformatf("rnd%0d", i), op, a, b, 4'($urandom), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/alu_seq16.md
# alu_seq16

16-bit operation sequencer that drives the 8-bit ALU from the requesting side. It accepts one 16-bit request at a time on a valid/ready interface. It splits the request into byte-wide ALU passes, chains carries and shift bits between the passes, and returns a registered 16-bit result on a second valid/ready interface. It sits between the datapath controller and the ALU, and owns every ALU input port while a request is in flight.

## Interface
- No parameters; all widths are fixed: bytes are 8 bits and operands are 16 bits.
- Clk  in  1  single clock; every register updates on the rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- ReqValid  in  1  request present.
- ReqReady  out  1  sequencer can accept a request; high exactly when the FSM is in IDLE.
- ReqOp  in  3  0 ADD, 1 XOR, 2 NOT (of OpA), 3 CMP (unsigned), 4 SHL, 5 SHR (logical), 6–7 illegal.
- OpA, OpB  in  16  operands; OpB is ignored for NOT, SHL and SHR.
- ShAmt  in  4  shift count for SHL and SHR, 0–15.
- RspValid  out  1  result valid.
- RspReady  in  1  consumer accepts the result.
- Result  out  16  result word; 0 for CMP and for illegal ops.
- Carry  out  1  ADD carry-out, or the last bit shifted out; 0 otherwise.
- Gt, Eq  out  1 each  CMP flags (OpA > OpB, OpA == OpB); 0 for all other ops.
- Err  out  1  illegal ReqOp.
- Aluop  out  3, mode  out  2, DatA/DatB  out  8 each, SCi/Ci/odd  out  1 each  ALU drive.
- Rslt  in  8, SCo/Co/gt/eq  in  1 each  ALU returns; the ALU is combinational.

## Operation
- FSM states: IDLE, LO, HI, DONE.
- Request capture: on ReqValid && ReqReady, latch ReqOp, OpA, OpB and ShAmt, and clear Result, Carry, Gt, Eq and Err.
  - Legal op, and not a shift with ShAmt 0: next state LO.
  - Shift with ShAmt 0: Result = OpA, Carry = 0, next state DONE.
  - Illegal op: Err = 1, next state DONE.
- ALU drive per pass (combinational from state and the latched request):
  - ADD/CMP: Aluop 000; SCi = 0; Ci = 0 in LO, and Ci = the captured lo-pass Co in HI.
  - XOR: Aluop 001.
  - NOT: Aluop 101, mode 01.
  - SHL: Aluop 101, mode 00.
  - SHR: Aluop 101, mode 10.
  - odd is always 0.
- Idle drive (IDLE and DONE): Aluop 010, all other ALU outputs 0.
- Byte order:
  - ADD, XOR, NOT, CMP and SHL: LO pass on byte 0, then HI pass on byte 1.
  - SHR: the LO state processes byte 1 first and the HI state processes byte 0, so the shifted-out bit travels downward.
- Shift bit chaining (the sequencer does this; the ALU does not shift in SCi):
  - SHL: hi result bit0 = lo-pass SCo. Carry = hi-pass SCo.
  - SHR: lo result bit7 = working hi byte bit0. Carry = working lo byte bit0.
- Shift loop: after HI, the 16-bit working word replaces OpA and a 4-bit counter decrements. The FSM returns to LO while the counter is nonzero, and goes to DONE otherwise. One bit is shifted per LO/HI pair.
- CMP flags: Gt = gt_hi | (eq_hi & gt_lo); Eq = eq_hi & eq_lo.
- ALU capture: ALU outputs are registered at the end of each LO or HI cycle.
- DONE: RspValid = 1 and all result outputs are held stable. On RspReady, the next state is IDLE.

## Timing
- Reset values: state IDLE, ReqReady 1, RspValid 0, Result 0, Carry/Gt/Eq/Err 0, Aluop 010, all other ALU drive outputs 0.
- Latency from accept edge to RspValid high:
  - ADD/XOR/NOT/CMP: 3 cycles.
  - Shifts: 1 + 2·ShAmt cycles.
  - ShAmt 0 or illegal op: 1 cycle.
- No new request is accepted while busy or in DONE. The earliest back-to-back accept is the cycle after the response handshake.
- RspValid stays high until RspReady is sampled high; it never drops without a handshake.
- Asynchronous reset mid-operation aborts immediately: all outputs return to their reset values and the in-flight result is discarded.

## Configuration
- ALU_SEQ_SHIFT_EN defined: SHL and SHR are supported as described.
- ALU_SEQ_SHIFT_EN undefined:
  - ReqOp 4 and 5 are illegal (Err = 1, 1-cycle response).
  - The shift counter and shift chaining logic are removed.
  - ShAmt is ignored.

## Test plan
- ADD 0x00FF + 0x0001 -> Result 0x0100, Carry 0, RspValid exactly 3 cycles after accept.
- ADD 0xFFFF + 0x0001 -> Result 0x0000, Carry 1. CMP 0x1234 vs 0x1233 -> Gt 1, Eq 0. CMP 0xABCD vs 0xABCD -> Gt 0, Eq 1.
- SHL 0x8181, ShAmt 1 -> Result 0x0302, Carry 1, latency 3. SHR 0x8181, ShAmt 4 -> Result 0x0818, Carry 0, latency 9.
- Backpressure: hold RspReady low for 5 cycles -> RspValid and Result stable throughout, ReqReady 0, and a ReqValid presented meanwhile is not accepted.
- ReqOp 6 -> Err 1, Result 0, latency 1. With ALU_SEQ_SHIFT_EN undefined, ReqOp 4 -> Err 1.
- Assert Reset_n low during the HI pass of an ADD -> all outputs reset asynchronously and no response is produced. A subsequent XOR 0x0F0F ^ 0x00FF -> Result 0x0FF0.
